// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : btn_debounce
//  Purpose  : Synchronises and debounces one push-button pin; emits a clean
//             level, edge pulses, a press-toggled level and a press count.
//  Revision : 1.0 - initial release
// ============================================================================
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       level_out,
  output logic       rise_pulse,
  output logic       fall_pulse,
  output logic       toggle_out,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {
    S_IDLE_LOW  = 2'd0,
    S_WAIT_HIGH = 2'd1,
    S_IDLE_HIGH = 2'd2,
    S_WAIT_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  logic             r_sync1;
  logic             r_sync2;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_level;
  logic             w_level_nxt;
  logic             r_rise;
  logic             w_rise_nxt;
  logic             r_fall;
  logic             w_fall_nxt;
  logic             r_toggle;
  logic             w_toggle_nxt;
  logic [7:0]       r_count;
  logic [7:0]       w_count_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_state  <= S_IDLE_LOW;
      r_cnt    <= '0;
      r_level  <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_toggle <= 1'b0;
      r_count  <= 8'd0;
    end else begin
      r_sync1  <= btn_in;
      r_sync2  <= r_sync1;
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_level  <= w_level_nxt;
      r_rise   <= w_rise_nxt;
      r_fall   <= w_fall_nxt;
      r_toggle <= w_toggle_nxt;
      r_count  <= w_count_nxt;
    end
  end

  // Any sample of the old level while waiting drops straight back to idle.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_level_nxt  = r_level;
    w_rise_nxt   = 1'b0;
    w_fall_nxt   = 1'b0;
    w_toggle_nxt = r_toggle;
    w_count_nxt  = r_count;
    case (r_state)
      S_IDLE_LOW: begin
        if (r_sync2) begin
          w_state_nxt = S_WAIT_HIGH;
          w_cnt_nxt   = c_cnt_one;
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      S_WAIT_HIGH: begin
        if (!r_sync2) begin
          w_state_nxt = S_IDLE_LOW;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_cnt_last) begin
          w_state_nxt  = S_IDLE_HIGH;
          w_cnt_nxt    = '0;
          w_level_nxt  = 1'b1;
          w_rise_nxt   = 1'b1;
          w_toggle_nxt = ~r_toggle;
          w_count_nxt  = r_count + 8'd1;
        end else begin
          w_cnt_nxt    = r_cnt + c_cnt_one;
        end
      end
      S_IDLE_HIGH: begin
        if (!r_sync2) begin
          w_state_nxt = S_WAIT_LOW;
          w_cnt_nxt   = c_cnt_one;
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      S_WAIT_LOW: begin
        if (r_sync2) begin
          w_state_nxt = S_IDLE_HIGH;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_cnt_last) begin
          w_state_nxt = S_IDLE_LOW;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + c_cnt_one;
        end
      end
      default: begin
        w_state_nxt = S_IDLE_LOW;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign level_out   = r_level;
  assign rise_pulse  = r_rise;
  assign fall_pulse  = r_fall;
  assign toggle_out  = r_toggle;
  assign press_count = r_count;

endmodule
`default_nettype wire
